alu_flag_unit: RTL and testbench

Registered condition-flag and overflow-trap stage directly downstream of the 32-bit ALU. It captures the ALU's zero, negative and overflow outputs into architectural flag registers when an instruction is marked flag-setting. It resolves conditional branches from those registered flags. On a signed overflow with trapping enabled, it raises a held trap request, latches the faulting PC and stalls the pipeline until the exception logic acknowledges.

---
 rtl/alu_flag_unit.sv | 134 +++++++++++++
 tb/tb_alu_flag_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// Condition-flag register and overflow-trap stage behind the 32-bit ALU.
// Captures Z/N/V, resolves branches from the registered flags, and holds a trap until acknowledged.
module alu_flag_unit #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_v,
  input  logic            flag_we,
  input  logic            trap_en,
  input  logic [PC_W-1:0] pc_in,
  input  logic [2:0]      br_cond,
  input  logic            ov_clr,
  input  logic            trap_ack,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_v,
  output logic            ov_sticky,
  output logic            br_take,
  output logic            trap_req,
  output logic [PC_W-1:0] epc,
  output logic            stall
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic            flag_z_reg, flag_z_next;
  logic            flag_n_reg, flag_n_next;
  logic            flag_v_reg, flag_v_next;
  logic            ov_sticky_reg, ov_sticky_next;
  logic            trap_req_reg, trap_req_next;
  logic [PC_W-1:0] epc_reg, epc_next;

  logic            capture;
  logic            ov_set;
  logic            trap_entry;
  logic [7:0]      cond_vec;

  // Flag writes are frozen while a trap is outstanding.
  assign capture    = (state_reg == RUN) && flag_we;
  assign ov_set     = capture && alu_v;
  assign trap_entry = ov_set && trap_en;

  always_comb begin
    state_next     = state_reg;
    flag_z_next    = flag_z_reg;
    flag_n_next    = flag_n_reg;
    flag_v_next    = flag_v_reg;
    ov_sticky_next = ov_sticky_reg;
    trap_req_next  = trap_req_reg;
    epc_next       = epc_reg;

    case (state_reg)
      RUN: begin
        if (trap_entry) begin
          state_next    = TRAP;
          trap_req_next = 1'b1;
          epc_next      = pc_in;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_next    = RUN;
          trap_req_next = 1'b0;
        end
      end
      default: begin
        state_next    = RUN;
        trap_req_next = 1'b0;
      end
    endcase

    if (capture) begin
      flag_z_next = alu_z;
      flag_n_next = alu_n;
      flag_v_next = alu_v;
    end

    // A new overflow beats a simultaneous clear.
    if (ov_set) begin
      ov_sticky_next = 1'b1;
    end else if (ov_clr) begin
      ov_sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      flag_z_reg    <= 1'b0;
      flag_n_reg    <= 1'b0;
      flag_v_reg    <= 1'b0;
      ov_sticky_reg <= 1'b0;
      trap_req_reg  <= 1'b0;
      epc_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      flag_z_reg    <= flag_z_next;
      flag_n_reg    <= flag_n_next;
      flag_v_reg    <= flag_v_next;
      ov_sticky_reg <= ov_sticky_next;
      trap_req_reg  <= trap_req_next;
      epc_reg       <= epc_next;
    end
  end

  // Branch conditions indexed directly by br_cond; only registered flags are used.
  assign cond_vec = {
    1'b1,                    // 111 always
    flag_n_reg ^ flag_v_reg, // 110 signed less-than
    flag_v_reg,              // 101
    ~flag_n_reg,             // 100
    flag_n_reg,              // 011
    ~flag_z_reg,             // 010
    flag_z_reg,              // 001
    1'b0                     // 000 never
  };

  assign stall     = (state_reg == TRAP);
  assign br_take   = cond_vec[br_cond] & ~stall;
  assign flag_z    = flag_z_reg;
  assign flag_n    = flag_n_reg;
  assign flag_v    = flag_v_reg;
  assign ov_sticky = ov_sticky_reg;
  assign trap_req  = trap_req_reg;
  assign epc       = epc_reg;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: driver pushes model expectations, monitor compares at negedge.
module tb_alu_flag_unit;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            alu_z = 1'b0, alu_n = 1'b0, alu_v = 1'b0;
  logic            flag_we = 1'b0, trap_en = 1'b0, ov_clr = 1'b0, trap_ack = 1'b0;
  logic [PC_W-1:0] pc_in = '0;
  logic [2:0]      br_cond = 3'd0;
  logic            flag_z, flag_n, flag_v, ov_sticky, br_take, trap_req, stall;
  logic [PC_W-1:0] epc;

  always #5 clk = ~clk;

  alu_flag_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .flag_we(flag_we), .trap_en(trap_en), .pc_in(pc_in), .br_cond(br_cond),
    .ov_clr(ov_clr), .trap_ack(trap_ack), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .ov_sticky(ov_sticky), .br_take(br_take), .trap_req(trap_req),
    .epc(epc), .stall(stall)
  );

  typedef struct {
    bit            z, n, v, st, tr, stl, br;
    bit [PC_W-1:0] epc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Architectural model: plain variables updated once per clock edge.
  bit            m_trap, m_z, m_n, m_v, m_st;
  bit [PC_W-1:0] m_epc;

  function automatic bit model_br(bit [2:0] c, bit z, bit n, bit v, bit trap);
    bit [7:0] tbl;
    tbl = {1'b1, n ^ v, v, ~n, n, ~z, z, 1'b0};
    return trap ? 1'b0 : tbl[c];
  endfunction

  task automatic model_step();
    if (reset) begin
      m_trap = 0; m_z = 0; m_n = 0; m_v = 0; m_st = 0; m_epc = '0;
    end else if (m_trap) begin
      if (ov_clr) m_st = 0;
      if (trap_ack) m_trap = 0;
    end else begin
      if (flag_we) begin
        m_z = alu_z; m_n = alu_n; m_v = alu_v;
      end
      if (flag_we && alu_v) m_st = 1;
      else if (ov_clr) m_st = 0;
      if (flag_we && alu_v && trap_en) begin
        m_trap = 1;
        m_epc  = pc_in;
      end
    end
  endtask

  // One cycle: commit the edge into the model, apply new inputs, push the expected view.
  task automatic drive(input bit rst, input bit we, input bit z, input bit n, input bit v,
                       input bit ten, input bit [PC_W-1:0] pc, input bit [2:0] c,
                       input bit clr, input bit ack);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    reset = rst; flag_we = we; alu_z = z; alu_n = n; alu_v = v; trap_en = ten;
    pc_in = pc; br_cond = c; ov_clr = clr; trap_ack = ack;
    e.z = m_z; e.n = m_n; e.v = m_v; e.st = m_st; e.tr = m_trap; e.stl = m_trap;
    e.epc = m_epc; e.br = model_br(c, m_z, m_n, m_v, m_trap);
    q.push_back(e);
  endtask

  task automatic idle(input bit [2:0] c, input bit ack);
    drive(0, 0, 0, 0, 0, 0, '0, c, 0, ack);
  endtask

  task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("flag_z", PC_W'(flag_z), PC_W'(e.z));
        chk("flag_n", PC_W'(flag_n), PC_W'(e.n));
        chk("flag_v", PC_W'(flag_v), PC_W'(e.v));
        chk("ov_sticky", PC_W'(ov_sticky), PC_W'(e.st));
        chk("trap_req", PC_W'(trap_req), PC_W'(e.tr));
        chk("stall", PC_W'(stall), PC_W'(e.stl));
        chk("epc", epc, e.epc);
        chk("br_take", PC_W'(br_take), PC_W'(e.br));
        $display("cycle t=%0t cond=%0d z=%0b n=%0b v=%0b st=%0b trap=%0b epc=%0h br=%0b",
                 $time, br_cond, flag_z, flag_n, flag_v, ov_sticky, trap_req, epc, br_take);
      end
    end
  end

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, 0, '0, 3'd7, 0, 0);
    drive(1, 0, 0, 0, 0, 0, '0, 3'd7, 0, 0);
    // Zero flag then branch on Z / !Z
    drive(0, 1, 1, 0, 0, 0, '0, 3'd1, 0, 0);
    idle(3'd1, 0);
    idle(3'd2, 0);
    // Overflow without trap (0x7FFFFFFF + 1)
    drive(0, 1, 0, 1, 1, 0, 32'h0000_1000, 3'd0, 0, 0);
    idle(3'd6, 0);
    // Overflow trap, 3 cycles without ack while flag writes are attempted
    drive(0, 1, 0, 0, 1, 1, 32'h0040_0018, 3'd7, 0, 0);
    drive(0, 1, 1, 0, 0, 0, '0, 3'd7, 0, 0);
    drive(0, 1, 1, 0, 0, 0, '0, 3'd1, 0, 0);
    drive(0, 1, 1, 0, 0, 0, '0, 3'd1, 0, 1);
    idle(3'd7, 0);
    idle(3'd7, 0);
    // Simultaneous clear and set, then clear alone
    drive(0, 1, 0, 0, 1, 0, '0, 3'd5, 1, 0);
    drive(0, 0, 0, 0, 0, 0, '0, 3'd5, 1, 0);
    idle(3'd5, 0);
    // Reset during TRAP
    drive(0, 1, 0, 1, 1, 1, 32'hDEAD_BEE0, 3'd3, 0, 0);
    idle(3'd7, 0);
    drive(1, 0, 0, 0, 0, 0, '0, 3'd7, 0, 0);
    idle(3'd7, 0);
    // Branch sweep over all flag combinations
    for (int f = 0; f < 8; f++) begin
      drive(0, 1, f[2], f[1], f[0], 0, '0, 3'd0, 1, 0);
      for (int c = 0; c < 8; c++) idle(c[2:0], 0);
    end
    // Ack already high on trap entry: one-cycle TRAP residency
    drive(0, 1, 0, 0, 1, 1, 32'h0000_0444, 3'd7, 0, 1);
    idle(3'd7, 1);
    idle(3'd7, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            1'($urandom), PC_W'($urandom), 3'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end
    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
